// File: rtl/sevseg_pkg.sv
// Shared constants for the seven-segment scan driver: segment bit positions,
// the hex glyph table and the scan-state encoding.
package sevseg_pkg;

    localparam int unsigned SEG_W   = 8;
    localparam int unsigned GLYPH_W = 7;
    localparam int unsigned SEG_A   = 0;
    localparam int unsigned SEG_G   = 6;
    localparam int unsigned SEG_DP  = 7;

    // Active-high gfedcba patterns, entry 0 at the right; b and d are lower case.
    localparam logic [15:0][GLYPH_W-1:0] GLYPH_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_e;

endpackage

// File: rtl/sevseg_scan_driver_glyph.sv
// Purely combinational nibble-to-glyph lookup (active-high segments a..g).
module hex_glyph_rom
    import sevseg_pkg::*;
(
    input  logic [3:0]         nibble_i,
    output logic [GLYPH_W-1:0] glyph_o
);

    assign glyph_o = GLYPH_TABLE[nibble_i];

endmodule

// File: rtl/sevseg_scan_driver.sv
// Multiplexed seven-segment scan driver with frame-synchronous shadow update,
// leading-zero blanking and PWM brightness gating of the digit enables.
module sevseg_scan_driver
    import sevseg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned DIM_BITS   = 3,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic [DIM_BITS-1:0]     brightness,
    output logic [SEG_W-1:0]        SEG,
    output logic [NUM_DIGITS-1:0]   DIGIT,
    output logic                    frame_tick
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PRE_W = $clog2(SCAN_DIV);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic             POL      = (ACTIVE_LOW != 0);

    scan_state_e                      state_q, state_d;
    logic [PRE_W-1:0]                 presc_q, presc_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [DIM_BITS-1:0]              pwm_q, pwm_d;
    logic                             load_pending_q, load_pending_d;
    logic [NUM_DIGITS-1:0][3:0]       stage_dig_q, stage_dig_d;
    logic [NUM_DIGITS-1:0]            stage_dp_q, stage_dp_d;
    logic [NUM_DIGITS-1:0][3:0]       shadow_dig_q, shadow_dig_d;
    logic [NUM_DIGITS-1:0]            shadow_dp_q, shadow_dp_d;
    logic [SEG_W-1:0]                 seg_q, seg_d;
    logic [NUM_DIGITS-1:0]            digit_q, digit_d;
    logic                             frame_tick_q, frame_tick_d;

    logic                             tc, wrap;
    logic [3:0]                       cur_nib;
    logic [GLYPH_W-1:0]               glyph;

    // Scan sequencing and load/shadow handshake. The first TC after reset
    // is treated as a wrap so that scanning always begins at digit 0.
    always_comb begin
        state_d        = state_q;
        presc_d        = presc_q + PRE_W'(1);
        idx_d          = idx_q;
        pwm_d          = pwm_q + DIM_BITS'(1);
        load_pending_d = load_pending_q;
        stage_dig_d    = stage_dig_q;
        stage_dp_d     = stage_dp_q;
        shadow_dig_d   = shadow_dig_q;
        shadow_dp_d    = shadow_dp_q;

        tc   = (presc_q == PRE_LAST);
        wrap = tc && ((state_q == ST_IDLE) || (idx_q == IDX_LAST));

        if (tc) begin
            presc_d = '0;
            state_d = ST_SCAN;
            idx_d   = wrap ? '0 : idx_q + IDX_W'(1);
        end

        // A load landing on the wrap TC defers the copy by one full frame.
        if (wrap && load_pending_q && !load) begin
            shadow_dig_d = stage_dig_q;
            shadow_dp_d  = stage_dp_q;
        end

        if (load) begin
            stage_dig_d    = digits;
            stage_dp_d     = dp;
            load_pending_d = 1'b1;
        end else if (wrap) begin
            load_pending_d = 1'b0;
        end
    end

    assign cur_nib = shadow_dig_d[idx_d];

    hex_glyph_rom u_glyph (
        .nibble_i (cur_nib),
        .glyph_o  (glyph)
    );

    // Output decode for the slot that starts on the coming edge.
    always_comb begin
        logic                  zero_above;
        logic [NUM_DIGITS-1:0] lz;
        logic                  blank;
        logic                  run;
        logic [SEG_W-1:0]      seg_act;
        logic [NUM_DIGITS-1:0] digit_act;

        zero_above = 1'b1;
        lz         = '0;
        seg_act    = '0;
        digit_act  = '0;
        run        = (state_d == ST_SCAN);

        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            zero_above = zero_above && (shadow_dig_d[i] == 4'd0);
            lz[i]      = zero_above;
        end
        blank = blank_lz && (idx_d != '0) && lz[idx_d];

        seg_act[SEG_G:SEG_A] = blank ? '0 : glyph;
        seg_act[SEG_DP]      = shadow_dp_d[idx_d];
        if (run && (pwm_d <= brightness)) begin
            digit_act[idx_d] = 1'b1;
        end

        seg_d        = (run ? seg_act : '0) ^ {SEG_W{POL}};
        digit_d      = digit_act ^ {NUM_DIGITS{POL}};
        frame_tick_d = wrap;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q        <= ST_IDLE;
            presc_q        <= '0;
            idx_q          <= '0;
            pwm_q          <= '0;
            load_pending_q <= 1'b0;
            stage_dig_q    <= '0;
            stage_dp_q     <= '0;
            shadow_dig_q   <= '0;
            shadow_dp_q    <= '0;
            seg_q          <= {SEG_W{POL}};
            digit_q        <= {NUM_DIGITS{POL}};
            frame_tick_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            presc_q        <= presc_d;
            idx_q          <= idx_d;
            pwm_q          <= pwm_d;
            load_pending_q <= load_pending_d;
            stage_dig_q    <= stage_dig_d;
            stage_dp_q     <= stage_dp_d;
            shadow_dig_q   <= shadow_dig_d;
            shadow_dp_q    <= shadow_dp_d;
            seg_q          <= seg_d;
            digit_q        <= digit_d;
            frame_tick_q   <= frame_tick_d;
        end
    end

    assign SEG        = seg_q;
    assign DIGIT      = digit_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sevseg_scan_driver.sv
// Self-checking bench: cycle-count based reference model plus directed and random stimulus.
module tb_sevseg_scan_driver;

    localparam int N  = 4;
    localparam int SD = 4;
    localparam int DB = 3;

    logic          CLK = 1'b0;
    logic          RST;
    logic [15:0]   digits;
    logic [3:0]    dp;
    logic          load;
    logic          blank_lz;
    logic [DB-1:0] brightness;
    logic [7:0]    SEG;
    logic [3:0]    DIGIT;
    logic          frame_tick;

    int checks = 0;
    int errors = 0;

    sevseg_scan_driver #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (SD),
        .DIM_BITS   (DB),
        .ACTIVE_LOW (1)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .digits     (digits),
        .dp         (dp),
        .load       (load),
        .blank_lz   (blank_lz),
        .brightness (brightness),
        .SEG        (SEG),
        .DIGIT      (DIGIT),
        .frame_tick (frame_tick)
    );

    always #5 CLK = ~CLK;

    // Active-high gfedcba glyphs, index = hex value.
    localparam logic [6:0] GL [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: k counts rising edges since reset release; slot s
    // starts after edge s*SD and shows digit (s-1) mod N.
    int          k;
    int          m_idx;
    bit          m_run, m_wrap, m_blank, m_pend;
    logic [15:0] m_stage, m_shadow;
    logic [3:0]  m_stage_dp, m_shadow_dp;
    logic [7:0]  m_s;
    logic [7:0]  e_seg;
    logic [3:0]  e_digit;
    logic        e_tick;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            k = 0; m_pend = 0;
            m_stage = '0; m_shadow = '0; m_stage_dp = '0; m_shadow_dp = '0;
            e_seg = 8'hFF; e_digit = 4'hF; e_tick = 1'b0;
        end else begin
            k++;
            m_run  = (k >= SD);
            m_idx  = m_run ? ((k / SD) - 1) % N : 0;
            m_wrap = m_run && (k % SD == 0) && (m_idx == 0);
            if (m_wrap && m_pend && !load) begin
                m_shadow = m_stage; m_shadow_dp = m_stage_dp; m_pend = 0;
            end
            if (load) begin
                m_stage = digits; m_stage_dp = dp; m_pend = 1;
            end
            m_blank = blank_lz && (m_idx > 0) && ((m_shadow >> (4 * m_idx)) == 16'd0);
            m_s     = {m_shadow_dp[m_idx], m_blank ? 7'h00 : GL[4'(m_shadow >> (4 * m_idx))]};
            e_seg   = m_run ? ~m_s : 8'hFF;
            e_digit = (m_run && (k % 8) <= int'(brightness)) ? 4'(~(4'b0001 << m_idx)) : 4'hF;
            e_tick  = m_wrap;
        end
    end

    always @(negedge CLK) begin
        chk("seg", SEG, e_seg);
        chk("digit", DIGIT, e_digit);
        chk("frame_tick", frame_tick, e_tick);
        chk("load_pending", dut.load_pending_q, m_pend);
    end

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse_load(input logic [15:0] d, input logic [3:0] p);
        digits = d; dp = p; load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    task automatic wait_tick();
        int t = 0;
        do begin
            @(negedge CLK);
            t++;
        end while (frame_tick !== 1'b1 && t < 100);
        chk("wait_tick", frame_tick, 1'b1);
    endtask

    logic [7:0] exp_seg [4];
    logic [3:0] exp_dig [4];
    int cnt;

    initial begin
        RST = 1'b1; digits = '0; dp = '0; load = 1'b0; blank_lz = 1'b0; brightness = 3'd7;
        step(2);
        chk("reset_seg", SEG, 8'hFF);
        chk("reset_digit", DIGIT, 4'hF);
        chk("reset_tick", frame_tick, 1'b0);
        RST = 1'b0;

        // Scan order with 1234
        pulse_load(16'h1234, 4'h0);
        wait_tick();
        wait_tick();
        exp_seg = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        exp_dig = '{4'hE, 4'hD, 4'hB, 4'h7};
        for (int i = 0; i < 4; i++) begin
            chk("scan_digit", DIGIT, exp_dig[i]);
            chk("scan_seg", SEG, exp_seg[i]);
            step(4);
        end
        chk("scan_next_tick", frame_tick, 1'b1);

        // Mid-frame load: current frame finishes, next frame shows ABCD
        step(5);
        pulse_load(16'hABCD, 4'h0);
        wait_tick();
        chk("midload_seg", SEG, 8'hA1);
        chk("midload_digit", DIGIT, 4'hE);

        // Load coincident with the wrap TC is deferred one frame
        step(15);
        digits = 16'h5678; dp = 4'h0; load = 1'b1;
        step(1);
        load = 1'b0;
        chk("wrapload_tick", frame_tick, 1'b1);
        chk("wrapload_pending", dut.load_pending_q, 1'b1);
        chk("wrapload_old_seg", SEG, 8'hA1);
        wait_tick();
        chk("wrapload_new_seg", SEG, 8'h80);
        chk("wrapload_cleared", dut.load_pending_q, 1'b0);

        // Leading-zero blanking
        blank_lz = 1'b1;
        pulse_load(16'h0070, 4'h0);
        wait_tick();
        exp_seg = '{8'hC0, 8'hF8, 8'hFF, 8'hFF};
        for (int i = 0; i < 4; i++) begin
            chk("blank_seg", SEG, exp_seg[i]);
            step(4);
        end

        // Brightness duty
        brightness = 3'd1;
        step(1);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (DIGIT != 4'hF) cnt++;
            step(1);
        end
        chk("duty_b1", cnt, 4);
        brightness = 3'd7;
        step(1);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (DIGIT != 4'hF) cnt++;
            step(1);
        end
        chk("duty_b7", cnt, 16);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            load   = ($urandom_range(0, 11) == 0);
            digits = 16'($urandom);
            if ($urandom_range(0, 3) == 0) digits = digits & 16'h00FF;
            dp     = 4'($urandom);
            if (i % 97 == 0)  blank_lz   = 1'($urandom);
            if (i % 61 == 0)  brightness = 3'($urandom);
            step(1);
        end
        load = 1'b0;

        // Reset mid-slot with a load pending
        brightness = 3'd7; blank_lz = 1'b1;
        digits = 16'h9999; dp = 4'hF; load = 1'b1;
        step(1);
        load = 1'b0;
        chk("pre_reset_pending", dut.load_pending_q, 1'b1);
        #2 RST = 1'b1;
        #1;
        chk("rst_seg", SEG, 8'hFF);
        chk("rst_digit", DIGIT, 4'hF);
        chk("rst_tick", frame_tick, 1'b0);
        chk("rst_pending", dut.load_pending_q, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        cnt = 0;
        do begin
            @(negedge CLK);
            cnt++;
        end while (frame_tick !== 1'b1 && cnt < 20);
        chk("first_tick_latency", cnt, 4);
        chk("post_reset_seg", SEG, 8'hC0);
        chk("post_reset_digit", DIGIT, 4'hE);
        step(4);
        chk("post_reset_blank", SEG, 8'hFF);
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
